terminal_controller: RTL and testbench
======================================

// Module: terminal_controller
// PURPOSE
//  Console sequencer that feeds the 80x25 text video generator: consumes a byte stream
//  (debug text from the host MCU), interprets printable/control codes, writes the char
//  buffer through its write port, and drives cursor_x/cursor_y/first_char/cursor_blink_on.
//  Scrolls by advancing first_char (ring buffer) and blanking the newly exposed row.
// PARAMETERS
//  COLS          80          chars per row (COLS*ROWS must be <= 2048)
//  ROWS          25          visible rows; ring size RING = COLS*ROWS = 2000
//  BLINK_CYCLES  12_600_000  clk cycles per cursor blink half-period
//  FILL_CHAR     8'h20       code written when clearing
// PORTS
//  clk              in   1   system/pixel clock
//  reset            in   1   synchronous, active-high
//  in_data          in   8   input byte
//  in_valid         in   1   in_data valid
//  in_ready         out  1   controller accepts in_data this cycle
//  wr_en            out  1   char buffer write strobe
//  wr_addr          out  11  char buffer write address, 0..RING-1
//  wr_data          out  8   char buffer write data
//  cursor_x         out  7   cursor column 0..COLS-1 (screen-relative)
//  cursor_y         out  5   cursor row 0..ROWS-1 (screen-relative)
//  first_char       out  11  ring address of top-left char; always a multiple of COLS
//  cursor_blink_on  out  1   cursor blink phase
// BEHAVIOUR
//  - All outputs registered. Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0,
//    cursor_x=0, cursor_y=0, first_char=0, cursor_blink_on=1; state=CLR_ALL, clear ptr=0.
//  - Accept = in_valid & in_ready. in_ready=1 only in IDLE; source holds data while ready=0.
//  - cursor address A = (first_char + cursor_y*COLS + cursor_x) mod RING.
//  - States:
//    CLR_ALL: each cycle wr_en=1, wr_data=FILL_CHAR, wr_addr=ptr, ptr++; after addr RING-1
//      -> IDLE. First write (addr 0) on the first clock after reset deasserts; in_ready
//      rises the cycle after the addr RING-1 write (RING+1 cycles total).
//    IDLE: on accept, effect appears on outputs the next cycle:
//      0x20..0x7E: wr_en=1, wr_addr=A, wr_data=byte; if x<COLS-1 then x++, else x=0 + newline.
//      0x0D CR: x=0. 0x0A LF: x=0 + newline. 0x08 BS: x-- if x>0, else no change; no write.
//      0x0C FF: first_char=0, x=y=0, ptr=0 -> CLR_ALL (RING writes, in_ready=0).
//      any other byte: consumed, ignored. Accept possible every cycle (1 byte/cycle).
//    newline: if y<ROWS-1 then y++; else scroll: first_char += COLS (RING-COLS wraps to 0),
//      y stays ROWS-1, -> CLR_ROW with ptr = old first_char (the new bottom row).
//    CLR_ROW: COLS cycles of wr_en=1, wr_data=FILL_CHAR, wr_addr=ptr..ptr+COLS-1, then IDLE;
//      in_ready=0 throughout. If the scroll came from a printable wrap, the printable write
//      occurs first (cycle after accept), CLR_ROW writes follow on consecutive cycles.
//  - cursor and first_char update in the same cycle as the corresponding write.
//  - wr_en=0 in IDLE when no printable accepted. Never two writes in one cycle.
//  - Blink: free-running counter 0..BLINK_CYCLES-1; cursor_blink_on toggles on wrap;
//    runs in all states.
//  - Reset mid-operation (any state) aborts it and restarts CLR_ALL from ptr=0.
// TESTING
//  1 reset, idle source -> wr_en 2000 cycles, addr 0..1999, data 0x20; then in_ready=1, cursor 0,0.
//  2 send 'A','B' back-to-back -> writes (0,0x41),(1,0x42) on consecutive cycles; cursor_x=2.
//  3 80 printables from x=0,y=0 -> last write addr 79, then cursor (0,1); no scroll, first_char=0.
//  4 cursor y=24, send LF -> first_char 0->80, writes 0x20 at addr 0..79, in_ready low 80 cycles,
//    cursor (0,24); repeat from first_char=1920 -> first_char=0, clears addr 1920..1999.
//  5 BS at x=0 -> no write, x=0; CR at x=17 -> x=0; byte 0x07 -> consumed, nothing changes.
//  6 FF after scrolls -> first_char=0, cursor 0,0, 2000 clear writes; reset asserted at clear
//    write #500 -> restarts at addr 0; stream held valid during CLR_* is not lost.

Source files
------------

// File: rtl/terminal_controller.sv
// terminal_controller: console sequencer for the 80x25 text video generator.
// Interprets a byte stream (printables plus CR/LF/BS/FF), writes the character
// ring buffer, tracks the cursor, and scrolls by advancing first_char around
// the ring and blanking the newly exposed bottom row.
module terminal_controller #(
  parameter int          COLS         = 80,
  parameter int          ROWS         = 25,
  parameter int          BLINK_CYCLES = 12_600_000,
  parameter logic [7:0]  FILL_CHAR    = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic [10:0] first_char,
  output logic        cursor_blink_on
);

  localparam int RING = COLS * ROWS;
  localparam int BW   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [1:0] CLR_ALL = 2'd0;
  localparam logic [1:0] IDLE    = 2'd1;
  localparam logic [1:0] CLR_ROW = 2'd2;

  logic [1:0]    state;
  logic [10:0]   ptr;        // next clear address
  logic [6:0]    row_cnt;    // writes done in the current row clear
  logic [BW-1:0] blink_cnt;

  logic        accept, is_print, is_cr, is_lf, is_bs, is_ff;
  logic        at_eol, at_bottom, do_nl, do_scroll;
  logic [11:0] lin_off, sum_addr;
  logic [10:0] cur_addr, fc_adv;

  // Byte decode, cursor ring address and the scrolled first_char value
  always_comb begin
    accept    = in_valid && in_ready;
    is_print  = (in_data >= 8'h20) && (in_data <= 8'h7E);
    is_cr     = (in_data == 8'h0D);
    is_lf     = (in_data == 8'h0A);
    is_bs     = (in_data == 8'h08);
    is_ff     = (in_data == 8'h0C);
    at_eol    = (cursor_x == 7'(COLS - 1));
    at_bottom = (cursor_y == 5'(ROWS - 1));
    do_nl     = accept && (is_lf || (is_print && at_eol));
    do_scroll = do_nl && at_bottom;
    // first_char < RING and the screen offset < RING, so one subtract wraps it
    lin_off   = 12'(cursor_y) * 12'(COLS) + 12'(cursor_x);
    sum_addr  = {1'b0, first_char} + lin_off;
    cur_addr  = (sum_addr >= 12'(RING)) ? 11'(sum_addr - 12'(RING)) : sum_addr[10:0];
    fc_adv    = (first_char == 11'(RING - COLS)) ? 11'd0 : first_char + 11'(COLS);
  end

  // Sequencer: full clear, byte interpretation, bottom-row clear after scroll
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLR_ALL;
      ptr        <= '0;
      row_cnt    <= '0;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cursor_x   <= '0;
      cursor_y   <= '0;
      first_char <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        CLR_ALL: begin
          wr_en    <= 1'b1;
          wr_addr  <= ptr;
          wr_data  <= FILL_CHAR;
          ptr      <= ptr + 11'd1;
          in_ready <= 1'b0;
          if (ptr == 11'(RING - 1)) state <= IDLE;
        end
        CLR_ROW: begin
          // the row starts on a multiple of COLS, so it never wraps the ring
          wr_en    <= 1'b1;
          wr_addr  <= ptr;
          wr_data  <= FILL_CHAR;
          ptr      <= ptr + 11'd1;
          row_cnt  <= row_cnt + 7'd1;
          in_ready <= 1'b0;
          if (row_cnt == 7'(COLS - 1)) state <= IDLE;
        end
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (is_print) begin
              wr_en   <= 1'b1;
              wr_addr <= cur_addr;
              wr_data <= in_data;
              if (!at_eol) cursor_x <= cursor_x + 7'd1;
            end
            if (is_cr || do_nl) cursor_x <= '0;
            if (is_bs && (cursor_x != 7'd0)) cursor_x <= cursor_x - 7'd1;
            if (do_nl && !at_bottom) cursor_y <= cursor_y + 5'd1;
            // scroll: old top row becomes the new bottom row and gets blanked
            if (do_scroll) begin
              first_char <= fc_adv;
              ptr        <= first_char;
              row_cnt    <= '0;
              state      <= CLR_ROW;
              in_ready   <= 1'b0;
            end
            if (is_ff) begin
              first_char <= '0;
              cursor_x   <= '0;
              cursor_y   <= '0;
              ptr        <= '0;
              state      <= CLR_ALL;
              in_ready   <= 1'b0;
            end
          end
        end
        default: begin
          state    <= CLR_ALL;
          ptr      <= '0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  // Free-running blink divider, toggles the phase on each wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt       <= '0;
      cursor_blink_on <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt       <= '0;
      cursor_blink_on <= ~cursor_blink_on;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_terminal_controller.sv
// tb_terminal_controller: directed vectors for the console sequencer.
// A table covers single-cycle byte handling in IDLE; hand sequences cover the
// full clear, scrolling, form feed, held input during clears and mid-clear reset.
module tb_terminal_controller;

  localparam int COLS  = 80;
  localparam int ROWS  = 25;
  localparam int RING  = COLS * ROWS;
  localparam int BLINK = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [10:0] first_char;
  logic        cursor_blink_on;

  int n_vec = 0;
  int n_err = 0;
  int ncyc  = 0;   // clock edges since reset deasserted

  terminal_controller #(.COLS(COLS), .ROWS(ROWS), .BLINK_CYCLES(BLINK), .FILL_CHAR(8'h20)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cursor_x(cursor_x),
    .cursor_y(cursor_y), .first_char(first_char), .cursor_blink_on(cursor_blink_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  din;
    logic        we;
    logic [10:0] addr;
    logic [7:0]  data;
    logic [6:0]  x;
    logic [4:0]  y;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) ncyc++;
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for in_ready, checking the clear writes are start.. consecutive, FILL data
  task automatic run_clear(input string nm, input int start, input int n);
    int  nw = 0;
    int  cyc = 0;
    bit  seq_ok = 1'b1;
    while (!in_ready && cyc < n + 10) begin
      tick();
      cyc++;
      if (wr_en) begin
        if (wr_addr != 11'((start + nw) % RING) || wr_data != 8'h20) seq_ok = 1'b0;
        nw++;
      end
    end
    chk({nm, " write count"}, nw, n);
    chk({nm, " write sequence"}, 32'(seq_ok), 1);
    chk({nm, " ready after clear"}, 32'(in_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int nw;
    int cyc;

    tbl[0]  = '{8'h41, 1'b1, 11'd0,  8'h41, 7'd1, 5'd0};  // 'A'
    tbl[1]  = '{8'h42, 1'b1, 11'd1,  8'h42, 7'd2, 5'd0};  // 'B' back-to-back
    tbl[2]  = '{8'h07, 1'b0, 11'd0,  8'h00, 7'd2, 5'd0};  // BEL ignored
    tbl[3]  = '{8'h0D, 1'b0, 11'd0,  8'h00, 7'd0, 5'd0};  // CR
    tbl[4]  = '{8'h08, 1'b0, 11'd0,  8'h00, 7'd0, 5'd0};  // BS at x=0
    tbl[5]  = '{8'h43, 1'b1, 11'd0,  8'h43, 7'd1, 5'd0};  // 'C' overwrites 0
    tbl[6]  = '{8'h08, 1'b0, 11'd0,  8'h00, 7'd0, 5'd0};  // BS
    tbl[7]  = '{8'h0A, 1'b0, 11'd0,  8'h00, 7'd0, 5'd1};  // LF
    tbl[8]  = '{8'h7A, 1'b1, 11'd80, 8'h7A, 7'd1, 5'd1};  // 'z' on row 1
    tbl[9]  = '{8'h7F, 1'b0, 11'd0,  8'h00, 7'd1, 5'd1};  // DEL ignored
    tbl[10] = '{8'h7E, 1'b1, 11'd81, 8'h7E, 7'd2, 5'd1};  // '~' top printable
    tbl[11] = '{8'h20, 1'b1, 11'd82, 8'h20, 7'd3, 5'd1};  // ' ' low printable
    tbl[12] = '{8'h1F, 1'b0, 11'd0,  8'h00, 7'd3, 5'd1};  // below printable
    tbl[13] = '{8'h80, 1'b0, 11'd0,  8'h00, 7'd3, 5'd1};  // high byte ignored

    // ---- reset state and full clear
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst wr_en", 32'(wr_en), 0);
    chk("rst wr_addr", 32'(wr_addr), 0);
    chk("rst wr_data", 32'(wr_data), 0);
    chk("rst cursor", {cursor_y, cursor_x}, 0);
    chk("rst first_char", 32'(first_char), 0);
    chk("rst blink", 32'(cursor_blink_on), 1);
    reset = 1'b0;
    ncyc  = 0;
    tick();
    chk("first clear write", {wr_en, wr_addr}, {1'b1, 11'd0});
    run_clear("init clear", 1, 1999);
    chk("init ready cycle", ncyc, RING + 1);
    chk("init cursor", {cursor_y, cursor_x}, 0);
    chk("init blink", 32'(cursor_blink_on), 32'(((ncyc / BLINK) % 2) == 0));

    // ---- table of single-cycle byte effects
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].din);
      chk($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(tbl[i].we));
      if (tbl[i].we) chk($sformatf("vec%0d write", i), {wr_addr, wr_data}, {tbl[i].addr, tbl[i].data});
      chk($sformatf("vec%0d cursor", i), {cursor_y, cursor_x}, {tbl[i].y, tbl[i].x});
      chk($sformatf("vec%0d ready", i), 32'(in_ready), 1);
    end

    // ---- form feed back to a clean screen
    send(8'h0C);
    chk("ff cursor", {cursor_y, cursor_x}, 0);
    chk("ff ready low", {in_ready, wr_en}, 0);
    run_clear("ff clear", 0, RING);

    // ---- 80 printables wrap to row 1 without scrolling
    ok = 1'b1;
    for (int i = 0; i < COLS; i++) begin
      send(8'(8'h30 + i % 10));
      if (!wr_en || wr_addr != 11'(i) || wr_data != 8'(8'h30 + i % 10)) ok = 1'b0;
    end
    chk("row fill writes", 32'(ok), 1);
    chk("row wrap cursor", {cursor_y, cursor_x}, {5'd1, 7'd0});
    chk("row wrap no scroll", {first_char, in_ready}, {11'd0, 1'b1});

    // ---- CR from mid-row
    for (int i = 0; i < 17; i++) send(8'h78);
    chk("x before cr", 32'(cursor_x), 17);
    send(8'h0D);
    chk("cr", {wr_en, cursor_y, cursor_x}, {1'b0, 5'd1, 7'd0});

    // ---- LF to the bottom, then scrolling
    for (int i = 0; i < 23; i++) send(8'h0A);
    chk("at bottom", {cursor_y, cursor_x, first_char}, {5'd24, 7'd0, 11'd0});
    send(8'h0A);
    chk("scroll1 first_char", 32'(first_char), 80);
    chk("scroll1 state", {in_ready, wr_en, cursor_y, cursor_x}, {1'b0, 1'b0, 5'd24, 7'd0});
    run_clear("scroll1", 0, COLS);
    for (int k = 0; k < 23; k++) begin
      send(8'h0A);
      run_clear($sformatf("scroll%0d", k + 2), COLS * (k + 1), COLS);
    end
    chk("first_char top", 32'(first_char), 1920);
    send(8'h0A);
    chk("scroll wrap first_char", 32'(first_char), 0);
    run_clear("scroll wrap", 1920, COLS);
    chk("scroll wrap cursor", {cursor_y, cursor_x}, {5'd24, 7'd0});

    // ---- printable at the bottom-right corner: write first, then row clear
    for (int i = 0; i < 79; i++) send(8'h71);
    chk("x at eol", 32'(cursor_x), 79);
    send(8'h57);
    chk("corner write", {wr_en, wr_addr, wr_data}, {1'b1, 11'd1999, 8'h57});
    chk("corner scroll", {first_char, cursor_y, cursor_x, in_ready}, {11'd80, 5'd24, 7'd0, 1'b0});
    run_clear("corner clear", 0, COLS);

    // ---- FF after scrolls with the next byte held valid through the clear
    send(8'h0C);
    chk("ff2 reset view", {first_char, cursor_y, cursor_x, in_ready}, 0);
    in_data  = 8'h4B;
    in_valid = 1'b1;
    run_clear("ff2 clear", 0, RING);
    tick();
    in_valid = 1'b0;
    chk("held byte write", {wr_en, wr_addr, wr_data}, {1'b1, 11'd0, 8'h4B});
    chk("held byte cursor", {cursor_y, cursor_x}, {5'd0, 7'd1});

    // ---- reset during the full clear
    send(8'h0C);
    nw = 0; cyc = 0;
    while (nw < 500 && cyc < 600) begin
      tick();
      cyc++;
      if (wr_en) nw++;
    end
    chk("clear write 500 addr", {wr_en, wr_addr}, {1'b1, 11'd499});
    reset = 1'b1;
    ncyc  = 0;
    tick();
    chk("mid rst outputs", {in_ready, wr_en, wr_addr, first_char}, 0);
    chk("mid rst blink", 32'(cursor_blink_on), 1);
    reset = 1'b0;
    run_clear("restart clear", 0, RING);
    chk("restart ready cycle", ncyc, RING + 1);
    repeat (7) tick();
    chk("blink phase", 32'(cursor_blink_on), 32'(((ncyc / BLINK) % 2) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
